switch_debounce: RTL and testbench

//  Conditions the raw slide switches before they reach the switch PIO input port.

---
 rtl/switch_pkg.sv | 18 +
 rtl/switch_debounce_bit.sv | 52 +++++
 rtl/switch_debounce.sv | 44 ++++
 tb/tb_switch_debounce.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch-conditioning constants and a width helper for counter sizing.
// No logic; all values are elaboration-time constants.
package switch_pkg;

    localparam int SW_WIDTH            = 18;
    localparam int SW_DEBOUNCE_DEFAULT = 500000;

    // Bits needed to hold 0..n-1; never returns 0 so a counter always exists.
    function automatic int clog2_safe(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, accepted level and change pulse.
// Level accepted DEBOUNCE_CYCLES+2 edges after the pin settles; free-running, no backpressure.
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = clog2_safe(SW_DEBOUNCE_DEFAULT)
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_changed,
    output logic accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* async_reg = "true" *) logic sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // High in the cycle before the new level is latched, so the top can register the OR alongside sw_changed.
    assign accept   = (sync2 != stable) && (cnt == CNT_LAST);
    assign sw_clean = stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable     <= 1'b0;
            cnt        <= '0;
            sw_changed <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt        <= '0;
                sw_changed <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                stable     <= sync2;
                cnt        <= '0;
                sw_changed <= 1'b1;
            end else begin
                cnt        <= cnt + 1'b1;
                sw_changed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH slide switches for the PIO in_port and flags accepted toggles.
// Latency DEBOUNCE_CYCLES+2 edges per bit; free-running filter, no handshake or backpressure.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_change
);

    localparam int CNT_W = clog2_safe(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .sw_raw     (sw_raw[i]),
            .sw_clean   (sw_clean[i]),
            .sw_changed (sw_changed[i]),
            .accept     (accept[i])
        );
    end

    // Built from the pre-register accept terms so it rises in the same cycle as sw_changed.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |accept;
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a short debounce window.
module tb_switch_debounce;

    localparam int W = 18;
    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;
    logic         any_change;

    int checks = 0;
    int errors = 0;

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_changed (sw_changed),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] clean,
                             input logic [W-1:0] chg, input logic any);
        check({tag, ".clean"}, 32'(sw_clean), 32'(clean));
        check({tag, ".chg"},   32'(sw_changed), 32'(chg));
        check({tag, ".any"},   32'(any_change), 32'(any));
    endtask

    logic [W-1:0] clean_exp;

    initial begin
        reset  = 1'b1;
        sw_raw = 18'h3FFFF;

        // 1: reset hold, then all-high re-qualifies after 6 edges
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("t1_rst", '0, '0, 1'b0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_all("t1_wait", '0, '0, 1'b0);
        end
        step();
        check_all("t1_accept", 18'h3FFFF, 18'h3FFFF, 1'b1);
        step();
        check_all("t1_after", 18'h3FFFF, '0, 1'b0);

        // Return to all-zero
        sw_raw = '0;
        for (int i = 0; i < 7; i++) step();
        check_all("t1_zero", '0, '0, 1'b0);

        // 2: bit 0 rises, accepted on edge 6 not 5
        sw_raw[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_all("t2_wait", '0, '0, 1'b0);
        end
        step();
        check_all("t2_accept", 18'h00001, 18'h00001, 1'b1);
        step();
        check_all("t2_after", 18'h00001, '0, 1'b0);

        // 3: bounce on bit 5 never qualifies
        begin
            logic [6:0] pat;
            pat = 7'b0111011; // LSB first: 1,1,0,1,1,1,0
            for (int i = 0; i < 7; i++) begin
                sw_raw[5] = pat[i];
                step();
                check_all("t3_bounce", 18'h00001, '0, 1'b0);
            end
            sw_raw[5] = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step();
                check_all("t3_settle", 18'h00001, '0, 1'b0);
            end
        end

        // 4: bits 3 and 17 together
        sw_raw[3]  = 1'b1;
        sw_raw[17] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_all("t4_wait", 18'h00001, '0, 1'b0);
        end
        step();
        check_all("t4_accept", 18'h20009, 18'h20008, 1'b1);
        step();
        check_all("t4_after", 18'h20009, '0, 1'b0);

        // 5: reset while bit 2 has cnt=2
        sw_raw[2] = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_all("t5_mid", 18'h20009, '0, 1'b0);
        reset = 1'b1;
        step();
        check_all("t5_rst", '0, '0, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_all("t5_wait", '0, '0, 1'b0);
        end
        step();
        check_all("t5_accept", 18'h2000D, 18'h2000D, 1'b1);
        step();
        check_all("t5_after", 18'h2000D, '0, 1'b0);

        // 6: bit 9 rises, then falls
        sw_raw[9] = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check_all("t6_high", 18'h2020D, '0, 1'b0);
        sw_raw[9] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_all("t6_wait", 18'h2020D, '0, 1'b0);
        end
        step();
        check_all("t6_accept", 18'h2000D, 18'h00200, 1'b1);
        step();
        check_all("t6_after", 18'h2000D, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
